// File: rtl/data_memory_ctrl_pkg.sv
// data_mem_pkg: shared FSM state type and the power-on/re-init word pattern.
// Contents: state_t (INIT sweep, RUN accept), init_word(index, depth, data_w).
package data_mem_pkg;
  typedef enum logic {INIT, RUN} state_t;
  // Lower half of memory holds its own index, upper half counts down from 0
  // (depth/2 - idx), truncated to data_w bits (two's-complement modulo).
  function automatic logic [63:0] init_word(input int idx, input int depth, input int data_w);
    logic [63:0] v;
    v = (idx < depth / 2) ? 64'(idx) : 64'(depth / 2 - idx);
    return (data_w >= 64) ? v : v & ((64'd1 << data_w) - 64'd1);
  endfunction
endpackage

// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: access bus between a requester (master) and the memory controller (slave).
// Signals: req/we/addr/wdata/init_req from master; ready/busy/rdata/rvalid/err from slave.
interface data_memory_ctrl_if #(parameter int DATA_W = 8, parameter int ADDR_W = 8);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              init_req;
  logic              ready;
  logic              busy;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              err;
  modport master (output req, we, addr, wdata, init_req, input ready, busy, rdata, rvalid, err);
  modport slave (input req, we, addr, wdata, init_req, output ready, busy, rdata, rvalid, err);
endinterface

// File: rtl/data_mem_array.sv
// data_mem_array: single-port storage, synchronous write and synchronous read.
// Ports: clk, reset (async active-low, clears only the read register), we, re,
// zero (load 0 instead of a word on a read), addr, wdata, rdata (registered).
module data_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int IW     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic              zero,
  input  logic [IW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  // Read register only moves on a read, so it holds between responses.
  always_ff @(posedge clk or negedge reset)
    if (!reset) rdata <= '0;
    else if (re) rdata <= zero ? '0 : mem[addr];
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: word memory with an init sweep FSM, latency-1 reads and out-of-range error pulses.
// Ports: clk, reset (async active-low), bus (slave side of data_memory_ctrl_if).
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic                clk,
  input  logic                reset,
  data_memory_ctrl_if.slave   bus
);
  localparam int IW = $clog2(DEPTH);
  state_t            state;
  logic [IW-1:0]     init_ptr;
  logic              rvalid_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] a;
  logic              acc;
  logic              oob;
  logic              last;
  logic              mem_we;
  logic [IW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  assign a         = bus.addr;
  assign acc       = bus.req && state == RUN;
  assign oob       = 32'(a) >= 32'(DEPTH);
  assign last      = init_ptr == IW'(DEPTH - 1);
  // The sweep owns the single port while in INIT; requests are ignored then.
  assign mem_we    = state == INIT || (acc && bus.we && !oob);
  assign mem_addr  = state == INIT ? init_ptr : (oob ? '0 : a[IW-1:0]);
  assign mem_wdata = state == INIT ? DATA_W'(init_word(int'(init_ptr), DEPTH, DATA_W)) : bus.wdata;
  data_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IW(IW)) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .re    (acc && !bus.we),
    .zero  (oob),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (rdata_q)
  );
  // An access accepted alongside init_req still completes: its response
  // registers load on the same edge that moves the FSM into INIT.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= INIT;
      init_ptr <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= acc && !bus.we;
      err_q    <= acc && oob;
      if (bus.init_req) begin
        state    <= INIT;
        init_ptr <= '0;
      end else if (state == INIT) begin
        init_ptr <= last ? '0 : init_ptr + 1'b1;
        if (last) state <= RUN;
      end
    end
  assign bus.ready  = state == RUN;
  assign bus.busy   = state == INIT;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed, table-driven bench for data_memory_ctrl (default and 16/64/6 configs).
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  data_memory_ctrl_if #(.DATA_W(8), .ADDR_W(8)) b1();
  data_memory_ctrl_if #(.DATA_W(16), .ADDR_W(6)) b2();

  data_memory_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(32)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  data_memory_ctrl #(.DATA_W(16), .ADDR_W(6), .DEPTH(64)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit we;
    int addr;
    int wdata;
    bit rv;
    bit er;
    int rd;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit we, input int addr, input int wdata);
    b1.req = 1'b1;
    b1.we = we;
    b1.addr = 8'(addr);
    b1.wdata = 8'(wdata);
  endtask

  task automatic idle();
    b1.req = 1'b0;
    b1.we = 1'b0;
    b1.init_req = 1'b0;
  endtask

  // Called at the negedge right after the sweep started (state already INIT);
  // counts negedges until ready, bounded.
  task automatic measure(input string nm, input int exp);
    int n = 0;
    while (b1.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(n), 64'(exp));
  endtask

  function automatic logic [7:0] pat8(input int i);
    return (i < 16) ? 8'(i) : 8'(16 - i);
  endfunction

  function automatic logic [15:0] pat16(input int i);
    return (i < 32) ? 16'(i) : 16'(32 - i);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    b1.addr = '0;
    b1.wdata = '0;
    b2.req = 1'b0;
    b2.we = 1'b0;
    b2.addr = '0;
    b2.wdata = '0;
    b2.init_req = 1'b0;
    vecs = '{
      '{1, 3,   8'hA5, 0, 0, 8'hF1},
      '{0, 3,   0,     1, 0, 8'hA5},
      '{0, 40,  0,     1, 1, 8'h00},
      '{1, 40,  8'h3C, 0, 1, 8'h00},
      '{0, 8,   0,     1, 0, 8'h08},
      '{0, 32,  0,     1, 1, 8'h00},
      '{1, 31,  8'h5A, 0, 0, 8'h00},
      '{0, 31,  0,     1, 0, 8'h5A},
      '{0, 0,   0,     1, 0, 8'h00},
      '{1, 255, 8'hFF, 0, 1, 8'h00},
      '{0, 17,  0,     1, 0, 8'hFF},
      '{0, 16,  0,     1, 0, 8'h00}
    };

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(b1.busy), 64'd1);
    chk("reset_ready", 64'(b1.ready), 64'd0);
    chk("reset_rvalid", 64'(b1.rvalid), 64'd0);
    chk("reset_err", 64'(b1.err), 64'd0);
    chk("reset_rdata", 64'(b1.rdata), 64'd0);
    reset = 1'b1;
    measure("sweep_after_reset", 32);

    for (int i = 0; i < 32; i++) begin
      drive(0, i, 0);
      @(negedge clk);
      chk($sformatf("init_rvalid[%0d]", i), 64'(b1.rvalid), 64'd1);
      chk($sformatf("init_rdata[%0d]", i), 64'(b1.rdata), 64'(pat8(i)));
      chk($sformatf("init_err[%0d]", i), 64'(b1.err), 64'd0);
    end
    idle();
    @(negedge clk);
    chk("idle_rvalid", 64'(b1.rvalid), 64'd0);
    chk("rdata_hold", 64'(b1.rdata), 64'hF1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      chk($sformatf("vec%0d_rvalid", i), 64'(b1.rvalid), 64'(vecs[i].rv));
      chk($sformatf("vec%0d_err", i), 64'(b1.err), 64'(vecs[i].er));
      chk($sformatf("vec%0d_rdata", i), 64'(b1.rdata), 64'(vecs[i].rd));
    end
    idle();
    @(negedge clk);

    // init_req during INIT restarts the sweep
    b1.init_req = 1'b1;
    @(negedge clk);
    b1.init_req = 1'b0;
    chk("restart_busy", 64'(b1.busy), 64'd1);
    repeat (9) @(negedge clk);
    b1.init_req = 1'b1;
    @(negedge clk);
    b1.init_req = 1'b0;
    measure("sweep_restart", 32);

    // write, then read accepted together with init_req
    drive(1, 5, 8'h77);
    @(negedge clk);
    drive(0, 5, 0);
    b1.init_req = 1'b1;
    @(negedge clk);
    b1.init_req = 1'b0;
    chk("init_read_rvalid", 64'(b1.rvalid), 64'd1);
    chk("init_read_rdata", 64'(b1.rdata), 64'h77);
    chk("init_read_busy", 64'(b1.busy), 64'd1);
    @(negedge clk);
    chk("ignored_while_busy", 64'(b1.rvalid), 64'd0);
    idle();
    measure("sweep_init_req", 31);
    drive(0, 5, 0);
    @(negedge clk);
    idle();
    chk("addr5_reinit", 64'(b1.rdata), 64'd5);

    // async reset aborts a pending read response
    drive(0, 17, 0);
    @(negedge clk);
    idle();
    chk("pre_abort_rvalid", 64'(b1.rvalid), 64'd1);
    chk("pre_abort_rdata", 64'(b1.rdata), 64'hFF);
    #2 reset = 1'b0;
    #1;
    chk("abort_rvalid", 64'(b1.rvalid), 64'd0);
    chk("abort_rdata", 64'(b1.rdata), 64'd0);
    chk("abort_busy", 64'(b1.busy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    measure("sweep_after_abort", 32);

    // reset mid-sweep at init_ptr = 10
    drive(0, 40, 0);
    b1.init_req = 1'b1;
    @(negedge clk);
    idle();
    chk("oob_init_err", 64'(b1.err), 64'd1);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midsweep_rvalid", 64'(b1.rvalid), 64'd0);
    chk("midsweep_err", 64'(b1.err), 64'd0);
    chk("midsweep_busy", 64'(b1.busy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    measure("sweep_after_midsweep", 32);
    drive(0, 20, 0);
    @(negedge clk);
    idle();
    chk("post_midsweep_rdata", 64'(b1.rdata), 64'hFC);

    // 16-bit / 64-word configuration
    begin
      int n = 0;
      int pulses = 0;
      while (b2.ready !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("w16_ready", 64'(b2.ready), 64'd1);
      for (int i = 0; i < 64; i++) begin
        b2.req = 1'b1;
        b2.we = 1'b0;
        b2.addr = 6'(i);
        @(negedge clk);
        if (b2.rvalid === 1'b1) pulses++;
        chk($sformatf("w16_rdata[%0d]", i), 64'(b2.rdata), 64'(pat16(i)));
        if (i == 33) chk("w16_word33", 64'(b2.rdata), 64'hFFFF);
      end
      b2.req = 1'b0;
      chk("w16_pulses", 64'(pulses), 64'd64);
      @(negedge clk);
      chk("w16_idle_rvalid", 64'(b2.rvalid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (>=4).
REQ-002 Parameter ADDR_W, default 8, address width in bits.
REQ-003 Parameter DEPTH, default 32, number of words; even; 2 <= DEPTH <= 2**ADDR_W.
REQ-004 The design SHALL use one clock; reset is asynchronous and active-low. Port list:
REQ-005 clk  input  1  sole clock, rising-edge active.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req  input  1  access request, accepted when req && ready.
REQ-008 we  input  1  1 = write, 0 = read; sampled with req.
REQ-009 addr  input  ADDR_W  word address; sampled with req.
REQ-010 wdata  input  DATA_W  write data; sampled with req.
REQ-011 init_req  input  1  one-cycle pulse that starts a re-initialisation sweep.
REQ-012 ready  output  1  high when an access can be accepted this cycle.
REQ-013 busy  output  1  high while an init sweep is in progress.
REQ-014 rdata  output  DATA_W  read data, valid when rvalid is high.
REQ-015 rvalid  output  1  one-cycle pulse marking a read response.
REQ-016 err  output  1  one-cycle pulse: the accepted access had addr >= DEPTH.

Function
REQ-017 The FSM SHALL have two states: INIT (sweep) and RUN (accept accesses).
REQ-018 INIT: one word per cycle at init_ptr = 0..DEPTH-1; word i gets i for i < DEPTH/2, else (DEPTH/2 - i) mod 2**DATA_W; the cycle after word DEPTH-1 is written, go to RUN.
REQ-019 ready = (state == RUN); busy = (state == INIT); req is ignored while busy, with no response.
REQ-020 init_req in RUN SHALL enter INIT with init_ptr = 0 next cycle; an access accepted in the same cycle is completed first (read response still issued, write still performed).
REQ-021 init_req in INIT SHALL restart the sweep from init_ptr = 0.
REQ-022 Accepted write with addr < DEPTH SHALL update the word at that rising edge; visible to a read accepted the next cycle.
REQ-023 Accepted read SHALL give rvalid = 1 and rdata = word[addr] exactly one cycle later (latency 1); back-to-back reads give one response per cycle.
REQ-024 Accepted access with addr >= DEPTH SHALL be dropped for storage; err pulses one cycle later; for a read, rvalid also pulses with rdata = 0.
REQ-025 rdata SHALL hold its last value when rvalid is low.
REQ-026 All outputs SHALL be registered, except ready and busy, which are decoded from the state register.

Reset
REQ-027 While reset is low: state = INIT, init_ptr = 0, rdata = 0, rvalid = 0, err = 0. Storage contents are undefined until the sweep rewrites them.
REQ-028 After reset deasserts, the sweep SHALL run; ready rises DEPTH cycles after the first rising edge.
REQ-029 Reset asserted mid-sweep or mid-access SHALL abort immediately; any pending response is discarded.

Structure
REQ-030 Package data_mem_pkg SHALL hold the state enum (INIT, RUN) and the init-pattern function (index, DEPTH, DATA_W -> word).
REQ-031 Storage SHALL be in sub-module data_mem_array: a single-port synchronous-write, synchronous-read array with no reset on contents; the control FSM, init_ptr, and response registers stay in the top level.

Verification
REQ-032 Defaults; release reset -> busy for 32 cycles, then ready = 1; reads 0..31 return 0..15, then 0x00,0xFF,...,0xF1.
REQ-033 Write 0xA5 to addr 3; read 3 next cycle -> rvalid one cycle after accept, rdata = 0xA5, err = 0.
REQ-034 Read addr 40 -> rvalid = 1, err = 1, rdata = 0; write addr 40 -> err = 1, and addr 8 (= 40 mod 32) still reads 8.
REQ-035 Write 0x77 to addr 5, then init_req in the same cycle as an accepted read of addr 5 -> response rdata = 0x77; busy for 32 cycles; then addr 5 reads 5.
REQ-036 Reset low at init_ptr = 10 -> rvalid and err are 0 at once; after release, the full 32-cycle sweep reruns.
REQ-037 DATA_W = 16, DEPTH = 64, ADDR_W = 6 -> word 33 reads 0xFFFF; 64 back-to-back reads give 64 consecutive rvalid pulses.
